// File: rtl/sdram_cmd_responder.sv
// SDRAM-like command target with power-up init, periodic refresh stalls and fixed-latency reads.
// Read data returns ReadLatency cycles after acceptance; registered cmdReady is low during init and stall windows.
`timescale 1ns/1ps
module sdram_cmd_responder #(
   parameter int AddrWidth   = 10,
   parameter int DataWidth   = 16,
   parameter int ReadLatency = 3,
   parameter int InitCycles  = 8,
   parameter int StallPeriod = 64,
   parameter int StallLength = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 cmdReady,
   input  logic                 cmdTrigger,
   input  logic [22:0]          cmdAddr,
   input  logic                 cmdWrite,
   input  logic [DataWidth-1:0] cmdWriteData,
   output logic [DataWidth-1:0] cmdReadData,
   output logic                 cmdReadDataValid,
   output logic                 addrError
);
   localparam int IW = $clog2(InitCycles + 1);
   localparam int SW = $clog2(StallPeriod + 1);
   localparam logic [IW-1:0] InitLast   = IW'(InitCycles - 1);
   localparam logic [SW-1:0] StallLast  = SW'(StallPeriod - 1);
   localparam logic [SW-1:0] StallStart = SW'(StallPeriod - StallLength);

   typedef enum logic [1:0] {INIT, RUN, STALL} state_t;

   state_t               state;
   logic [IW-1:0]        init_cnt;
   logic [SW-1:0]        stall_cnt;
   logic [SW-1:0]        stall_nxt;

   logic [DataWidth-1:0] mem [2**AddrWidth];
   logic [AddrWidth-1:0] word;
   logic                 in_range;
   logic                 accept;
   logic                 rd_vld [ReadLatency];
   logic [DataWidth-1:0] rd_dat [ReadLatency];

   assign word      = cmdAddr[AddrWidth-1:0];
   assign in_range  = ~|cmdAddr[22:AddrWidth];
   assign accept    = cmdReady & cmdTrigger & ~rst;
   assign stall_nxt = (stall_cnt == StallLast) ? '0 : stall_cnt + 1'b1;

   // cmdReady is decided from the next stall count so it lines up with the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         init_cnt  <= '0;
         stall_cnt <= '0;
         cmdReady  <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (init_cnt == InitLast) begin
                  state     <= RUN;
                  stall_cnt <= '0;
                  cmdReady  <= 1'b1;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            default: begin
               stall_cnt <= stall_nxt;
               if (stall_nxt >= StallStart) begin
                  state    <= STALL;
                  cmdReady <= 1'b0;
               end else begin
                  state    <= RUN;
                  cmdReady <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept && cmdWrite && in_range) begin
         mem[word] <= cmdWriteData;
      end
   end

   // Stage 0 samples storage at the acceptance edge; later stages only delay, so order is preserved.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ReadLatency; i++) begin
            rd_vld[i] <= 1'b0;
            rd_dat[i] <= '0;
         end
      end else begin
         rd_vld[0] <= accept & ~cmdWrite;
         rd_dat[0] <= (accept && !cmdWrite && in_range) ? mem[word] : '0;
         for (int i = 1; i < ReadLatency; i++) begin
            rd_vld[i] <= rd_vld[i-1];
            rd_dat[i] <= rd_dat[i-1];
         end
      end
   end

   assign cmdReadDataValid = rd_vld[ReadLatency-1];
   assign cmdReadData      = rd_dat[ReadLatency-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         addrError <= 1'b0;
      end else if (accept && !in_range) begin
         addrError <= 1'b1;
      end
   end
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed bench for sdram_cmd_responder: vector table for reset/init/basic access, then
// hand-written sequences checked against a ready-timing model and a read scoreboard.
`timescale 1ns/1ps
module tb_sdram_cmd_responder;
   localparam int RL    = 3;
   localparam int INIT  = 8;
   localparam int PER   = 64;
   localparam int SLEN  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_ready;
   logic        trg = 1'b0;
   logic [22:0] adr = '0;
   logic        wr = 1'b0;
   logic [15:0] wd = '0;
   logic [15:0] rd_dat;
   logic        rd_vld;
   logic        addr_err;

   sdram_cmd_responder dut (
      .clk              (clk),
      .rst              (rst),
      .cmdReady         (cmd_ready),
      .cmdTrigger       (trg),
      .cmdAddr          (adr),
      .cmdWrite         (wr),
      .cmdWriteData     (wd),
      .cmdReadData      (rd_dat),
      .cmdReadDataValid (rd_vld),
      .addrError        (addr_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int r0 = 0;
   int vld_seen = 0;
   logic mon_en = 1'b0;

   typedef struct {
      logic        rst, trg, wr;
      logic [22:0] adr;
      logic [15:0] wd;
      logic        rdy, vld;
      logic [15:0] rd;
      logic        err;
   } vec_t;

   typedef struct {
      logic [15:0] dat;
      int          due;
   } rd_t;

   vec_t        tbl [19];
   rd_t         exp_q [$];
   logic [15:0] mem_m [1024];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic model_ready(input int n);
      int d;
      d = n - r0;
      if (d < INIT) return 1'b0;
      return ((d - INIT) % PER) < (PER - SLEN);
   endfunction

   function automatic vec_t mk(input logic r, input logic t, input logic w, input logic [22:0] a,
                               input logic [15:0] d, input logic rdy, input logic v,
                               input logic [15:0] q, input logic e);
      vec_t x;
      x.rst = r; x.trg = t; x.wr = w; x.adr = a; x.wd = d;
      x.rdy = rdy; x.vld = v; x.rd = q; x.err = e;
      return x;
   endfunction

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   // Checks every cycle: cmdReady against the timing model, read strobes against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_vld) vld_seen = vld_seen + 1;
         chk("ready", cmd_ready, model_ready(cyc));
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rd_vld", rd_vld, 1);
            chk("rd_dat", rd_dat, exp_q[0].dat);
            void'(exp_q.pop_front());
         end else begin
            chk("idle_vld", rd_vld, 0);
            chk("idle_dat", rd_dat, 0);
         end
      end
   end

   task automatic issue(input logic w, input logic [22:0] a, input logic [15:0] d);
      logic ok;
      logic in_rng;
      int   budget;
      rd_t  e;
      trg = 1'b1; wr = w; adr = a; wd = d;
      budget = 200;
      forever begin
         ok = model_ready(cyc);
         step();
         if (ok) break;
         budget--;
         if (budget == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL issue_timeout at cycle %0d: got no acceptance, expected one within 200 cycles", cyc);
            return;
         end
      end
      in_rng = (a[22:10] == 13'd0);
      if (w) begin
         if (in_rng) mem_m[a[9:0]] = d;
      end else begin
         e.dat = in_rng ? mem_m[a[9:0]] : 16'h0000;
         e.due = cyc + RL - 1;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1; trg = 1'b1; wr = 1'b1; adr = 23'h400; wd = 16'hDEAD;
      step();
      r0 = cyc;
      exp_q.delete();
      chk("rst_ready", cmd_ready, 0);
      chk("rst_vld", rd_vld, 0);
      chk("rst_dat", rd_dat, 0);
      chk("rst_err", addr_err, 0);
      rst = 1'b0; trg = 1'b0; wr = 1'b0;
      mon_en = 1'b1;
   endtask

   initial begin
      int seen0;
      // Reset and INIT with a held out-of-range write that must be ignored, then basic accesses.
      tbl[0]  = mk(1, 1, 1, 23'h400, 16'hDEAD, 0, 0, 16'h0000, 0);
      for (int i = 1; i <= 7; i++)
         tbl[i] = mk(0, 1, 1, 23'h400, 16'hDEAD, 0, 0, 16'h0000, 0);
      tbl[8]  = mk(0, 1, 1, 23'h400, 16'hDEAD, 1, 0, 16'h0000, 0);
      tbl[9]  = mk(0, 1, 1, 23'h005, 16'hA5A5, 1, 0, 16'h0000, 0);
      tbl[10] = mk(0, 1, 0, 23'h005, 16'h0000, 1, 0, 16'h0000, 0);
      tbl[11] = mk(0, 1, 1, 23'h000, 16'h1234, 1, 0, 16'h0000, 0);
      tbl[12] = mk(0, 0, 0, 23'h000, 16'h0000, 1, 1, 16'hA5A5, 0);
      tbl[13] = mk(0, 1, 1, 23'h400, 16'hBEEF, 1, 0, 16'h0000, 1);
      tbl[14] = mk(0, 1, 0, 23'h400, 16'h0000, 1, 0, 16'h0000, 1);
      tbl[15] = mk(0, 1, 0, 23'h000, 16'h0000, 1, 0, 16'h0000, 1);
      tbl[16] = mk(0, 0, 0, 23'h000, 16'h0000, 1, 1, 16'h0000, 1);
      tbl[17] = mk(0, 0, 0, 23'h000, 16'h0000, 1, 1, 16'h1234, 1);
      tbl[18] = mk(0, 0, 0, 23'h000, 16'h0000, 1, 0, 16'h0000, 1);

      for (int i = 0; i < 19; i++) begin
         rst = tbl[i].rst; trg = tbl[i].trg; wr = tbl[i].wr; adr = tbl[i].adr; wd = tbl[i].wd;
         step();
         chk($sformatf("row%0d_ready", i), cmd_ready, tbl[i].rdy);
         chk($sformatf("row%0d_vld", i), rd_vld, tbl[i].vld);
         chk($sformatf("row%0d_dat", i), rd_dat, tbl[i].rd);
         chk($sformatf("row%0d_err", i), addr_err, tbl[i].err);
      end

      // Mid-operation reset, then watch init and the first stall window idle.
      do_reset();
      repeat (80) step();

      for (int a = 0; a < 1024; a++) issue(1'b1, 23'(a), ~16'(a));
      trg = 1'b0;
      step();

      // Start back-to-back reads five edges before a stall window so they straddle it.
      for (int k = 0; k < 200; k++) begin
         if (((cyc - r0 - INIT) % PER) == (PER - SLEN - 5)) break;
         step();
      end
      seen0 = vld_seen;
      for (int a = 0; a < 10; a++) issue(1'b0, 23'(a), 16'h0000);
      trg = 1'b0;
      repeat (8) step();
      chk("span_strobe_count", vld_seen - seen0, 10);

      // Out-of-range write must not alias onto address 0.
      issue(1'b1, 23'h000400, 16'h1111);
      issue(1'b0, 23'h000400, 16'h0000);
      issue(1'b0, 23'h000000, 16'h0000);
      issue(1'b0, 23'h400003, 16'h0000);
      trg = 1'b0;
      repeat (6) step();
      chk("addr_err_set", addr_err, 1);

      issue(1'b1, 23'h007, 16'h5A5A);
      issue(1'b0, 23'h007, 16'h0000);
      trg = 1'b0;
      repeat (6) step();

      // Reset one edge after the last of three reads: the younger reads must never strobe.
      issue(1'b0, 23'h001, 16'h0000);
      issue(1'b0, 23'h002, 16'h0000);
      issue(1'b0, 23'h003, 16'h0000);
      seen0 = vld_seen;
      do_reset();
      repeat (30) step();
      chk("post_reset_strobes", vld_seen - seen0, 0);
      chk("post_reset_err", addr_err, 0);

      mon_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
      $fatal(1);
   end
endmodule
